// File: rtl/dac_tx_if.sv
// Transmit-side DAC interface: valid/ready sample stream -> 8-deep FIFO -> paced 12-bit DAC bus.
// Sample rate set by a clock divider; optional two's complement to offset-binary conversion.
module dac_tx_if #(
  parameter int DW      = 12,
  parameter int FIFO_AW = 3,
  parameter int DIV     = 4,
  parameter int TWOS_IN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DW-1:0]      s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               clr_underrun,
  output logic               underrun,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [DW-1:0]      DAC_DATA,
  output logic               DAC_WRT,
  output logic               DAC_SLEEP
);

  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LVL_HALF = (FIFO_AW + 1)'(DEPTH / 2);
  localparam logic [7:0]         CNT_LAST = 8'(DIV - 1);
  localparam logic [7:0]         CNT_HALF = 8'(DIV / 2);
  localparam logic [DW-1:0]      MIDSCALE = {1'b1, {(DW - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } state_t;

  state_t               state, state_n;
  logic [FIFO_AW-1:0]   wr_ptr, wr_ptr_n;
  logic [FIFO_AW-1:0]   rd_ptr, rd_ptr_n;
  logic [FIFO_AW:0]     level, level_n;
  logic [7:0]           cnt, cnt_n;
  logic [DW-1:0]        dac_data_n;
  logic                 dac_wrt_n;
  logic                 dac_sleep_n;
  logic                 underrun_n;
  logic                 do_push;
  logic                 do_pop;
  logic                 strobe;
  logic [DW-1:0]        head;
  logic [DW-1:0]        mem [DEPTH];

  function automatic logic [DW-1:0] to_dac(input logic [DW-1:0] d);
    if (TWOS_IN != 0) return {~d[DW-1], d[DW-2:0]};
    else              return d;
  endfunction

  assign s_ready    = (state != IDLE) && (level != LVL_FULL);
  assign fifo_level = level;
  assign head       = mem[rd_ptr];

  // Sample strobe: the edge on which the divider wraps DIV-1 -> 0.
  assign strobe  = (state == RUN) && (cnt == CNT_LAST);
  assign do_push = en && s_valid && s_ready;
  assign do_pop  = en && strobe && (level != '0);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    level_n    = level;
    cnt_n      = cnt;
    dac_data_n = DAC_DATA;
    underrun_n = underrun;

    if (do_push) wr_ptr_n = wr_ptr + FIFO_AW'(1);
    if (do_pop)  rd_ptr_n = rd_ptr + FIFO_AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   level_n = level + (FIFO_AW + 1)'(1);
      2'b01:   level_n = level - (FIFO_AW + 1)'(1);
      default: level_n = level;
    endcase

    unique case (state)
      IDLE: begin
        state_n    = FILL;
        cnt_n      = '0;
        dac_data_n = MIDSCALE;
      end
      FILL: begin
        cnt_n      = '0;
        dac_data_n = MIDSCALE;
        if (level_n >= LVL_HALF) state_n = RUN;
      end
      RUN: begin
        cnt_n = strobe ? 8'd0 : cnt + 8'd1;
        if (strobe) begin
          if (level != '0) dac_data_n = to_dac(head);
          else             dac_data_n = MIDSCALE;
        end
      end
      default: state_n = IDLE;
    endcase

    // A missed strobe wins over a clear arriving in the same cycle.
    if (en && strobe && (level == '0)) underrun_n = 1'b1;
    else if (clr_underrun)             underrun_n = 1'b0;

    if (!en) begin
      state_n    = IDLE;
      wr_ptr_n   = '0;
      rd_ptr_n   = '0;
      level_n    = '0;
      cnt_n      = '0;
      dac_data_n = MIDSCALE;
    end

    dac_wrt_n   = (state_n == RUN) && (cnt_n >= CNT_HALF);
    dac_sleep_n = (state_n == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      cnt       <= '0;
      DAC_DATA  <= MIDSCALE;
      DAC_WRT   <= 1'b0;
      DAC_SLEEP <= 1'b1;
      underrun  <= 1'b0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      level     <= level_n;
      cnt       <= cnt_n;
      DAC_DATA  <= dac_data_n;
      DAC_WRT   <= dac_wrt_n;
      DAC_SLEEP <= dac_sleep_n;
      underrun  <= underrun_n;
    end
  end

  // NOTE: the storage array is deliberately not reset; level and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= s_data;
  end

endmodule

// File: tb/tb_dac_tx_if.sv
// Directed bench for dac_tx_if: vector table for fill/run/underrun, queue model for the
// backpressure, enable-drop and async-reset sequences. A TWOS_IN=0 twin checks raw pass-through.
module tb_dac_tx_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        clr_underrun;
  logic        underrun;
  logic [3:0]  fifo_level;
  logic [11:0] dac_data;
  logic        dac_wrt;
  logic        dac_sleep;

  logic        raw_ready;
  logic        raw_underrun;
  logic [3:0]  raw_level;
  logic [11:0] raw_data;
  logic        raw_wrt;
  logic        raw_sleep;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dac_tx_if dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .clr_underrun (clr_underrun),
    .underrun     (underrun),
    .fifo_level   (fifo_level),
    .DAC_DATA     (dac_data),
    .DAC_WRT      (dac_wrt),
    .DAC_SLEEP    (dac_sleep)
  );

  dac_tx_if #(.TWOS_IN(0)) dut_raw (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (raw_ready),
    .clr_underrun (clr_underrun),
    .underrun     (raw_underrun),
    .fifo_level   (raw_level),
    .DAC_DATA     (raw_data),
    .DAC_WRT      (raw_wrt),
    .DAC_SLEEP    (raw_sleep)
  );

  typedef struct {
    logic        en;
    logic        valid;
    logic [11:0] data;
    logic        clr;
    logic        rdy;
    logic [3:0]  lvl;
    logic [11:0] dac;
    logic [11:0] raw;
    logic        wrt;
    logic        slp;
    logic        ur;
  } vec_t;

  vec_t tbl[$];

  // Reference model: 0 idle, 1 fill, 2 run.
  int          m_state;
  int          m_cnt;
  logic [11:0] q[$];
  logic [11:0] m_dac;
  logic [11:0] m_raw;
  logic        m_wrt;
  logic        m_sleep;
  logic        m_ur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    q.delete();
    m_dac   = 12'h800;
    m_raw   = 12'h800;
    m_wrt   = 1'b0;
    m_sleep = 1'b1;
    m_ur    = 1'b0;
  endtask

  function automatic logic model_ready();
    return (m_state != 0) && (q.size() < 8);
  endfunction

  task automatic model_edge(input logic e, input logic v, input logic [11:0] d, input logic c);
    logic push;
    logic miss;
    logic [11:0] w;
    push = v && model_ready();
    miss = 1'b0;
    if (!e) begin
      q.delete();
      m_state = 0;
      m_cnt   = 0;
      m_dac   = 12'h800;
      m_raw   = 12'h800;
    end else begin
      case (m_state)
        0: m_state = 1;
        1: begin
          if (push) q.push_back(d);
          if (q.size() >= 4) m_state = 2;
          m_cnt = 0;
        end
        default: begin
          if (m_cnt == 3) begin
            if (q.size() > 0) begin
              w     = q.pop_front();
              m_dac = w ^ 12'h800;
              m_raw = w;
            end else begin
              m_dac = 12'h800;
              m_raw = 12'h800;
              miss  = 1'b1;
            end
          end
          if (push) q.push_back(d);
          m_cnt = (m_cnt + 1) % 4;
        end
      endcase
    end
    if (miss)   m_ur = 1'b1;
    else if (c) m_ur = 1'b0;
    m_wrt   = (m_state == 2) && (m_cnt >= 2);
    m_sleep = (m_state == 0);
  endtask

  // Called at a negedge; leaves the bench at the following negedge.
  task automatic drive_edge(input logic e, input logic v, input logic [11:0] d, input logic c);
    en           = e;
    s_valid      = v;
    s_data       = d;
    clr_underrun = c;
    @(posedge clk);
    model_edge(e, v, d, c);
    @(negedge clk);
  endtask

  task automatic compare_all(input string tag, input logic rdy, input logic [3:0] lvl,
                             input logic [11:0] dac, input logic [11:0] raw, input logic wrt,
                             input logic slp, input logic ur);
    check({tag, ".ready"},    32'(s_ready),    32'(rdy));
    check({tag, ".level"},    32'(fifo_level), 32'(lvl));
    check({tag, ".dac"},      32'(dac_data),   32'(dac));
    check({tag, ".raw_dac"},  32'(raw_data),   32'(raw));
    check({tag, ".wrt"},      32'(dac_wrt),    32'(wrt));
    check({tag, ".sleep"},    32'(dac_sleep),  32'(slp));
    check({tag, ".underrun"}, 32'(underrun),   32'(ur));
  endtask

  task automatic model_step(input string tag, input logic e, input logic v,
                            input logic [11:0] d, input logic c);
    check({tag, ".ready_pre"}, 32'(s_ready), 32'(model_ready()));
    drive_edge(e, v, d, c);
    compare_all(tag, model_ready(), 4'(q.size()), m_dac, m_raw, m_wrt, m_sleep, m_ur);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] nxt;
    logic        saw_full;
    int          k;

    //            en valid data    clr rdy lvl dac     raw     wrt slp ur
    tbl.push_back('{0, 1, 12'h000, 0, 0, 0, 12'h800, 12'h800, 0, 1, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 0, 12'h800, 12'h800, 0, 0, 0});
    tbl.push_back('{1, 1, 12'h000, 0, 1, 1, 12'h800, 12'h800, 0, 0, 0});
    tbl.push_back('{1, 1, 12'h7FF, 0, 1, 2, 12'h800, 12'h800, 0, 0, 0});
    tbl.push_back('{1, 1, 12'h800, 0, 1, 3, 12'h800, 12'h800, 0, 0, 0});
    tbl.push_back('{1, 1, 12'hFFF, 0, 1, 4, 12'h800, 12'h800, 0, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 4, 12'h800, 12'h800, 0, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 4, 12'h800, 12'h800, 1, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 4, 12'h800, 12'h800, 1, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 3, 12'h800, 12'h000, 0, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 3, 12'h800, 12'h000, 0, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 3, 12'h800, 12'h000, 1, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 3, 12'h800, 12'h000, 1, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 2, 12'hFFF, 12'h7FF, 0, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 2, 12'hFFF, 12'h7FF, 0, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 2, 12'hFFF, 12'h7FF, 1, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 2, 12'hFFF, 12'h7FF, 1, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 1, 12'h000, 12'h800, 0, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 1, 12'h000, 12'h800, 0, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 1, 12'h000, 12'h800, 1, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 1, 12'h000, 12'h800, 1, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 0, 12'h7FF, 12'hFFF, 0, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 0, 12'h7FF, 12'hFFF, 0, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 0, 12'h7FF, 12'hFFF, 1, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 0, 12'h7FF, 12'hFFF, 1, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 0, 12'h800, 12'h800, 0, 0, 1});
    tbl.push_back('{1, 0, 12'h000, 1, 1, 0, 12'h800, 12'h800, 0, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 0, 12'h800, 12'h800, 1, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 0, 1, 0, 12'h800, 12'h800, 1, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 1, 1, 0, 12'h800, 12'h800, 0, 0, 1});

    rst          = 1'b1;
    en           = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    clr_underrun = 1'b0;
    model_reset();
    #3;
    compare_all("reset", 0, 0, 12'h800, 12'h800, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;

    // Fill, four paced outputs, underrun set/clear/collision.
    foreach (tbl[i]) begin
      drive_edge(tbl[i].en, tbl[i].valid, tbl[i].data, tbl[i].clr);
      compare_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].lvl, tbl[i].dac, tbl[i].raw,
                  tbl[i].wrt, tbl[i].slp, tbl[i].ur);
    end

    // Continuous s_valid: FIFO saturates, then one push per pop.
    nxt      = 12'h105;
    saw_full = 1'b0;
    for (int i = 0; i < 60; i++) begin
      logic acc;
      acc = model_ready();
      model_step($sformatf("bp%0d", i), 1, 1, nxt, 0);
      if (acc) nxt = nxt + 12'h25;
      if (q.size() == 8) saw_full = 1'b1;
    end
    check("bp.saw_full", 32'(saw_full), 32'd1);

    // Drain to level 5, then drop en.
    k = 0;
    while (q.size() != 5 && k < 40) begin
      model_step($sformatf("drain%0d", k), 1, 0, 12'h000, 0);
      k++;
    end
    check("drain.level5", 32'(fifo_level), 32'd5);
    model_step("en_drop", 0, 1, 12'h555, 0);
    check("en_drop.level", 32'(fifo_level), 32'd0);
    check("en_drop.dac",   32'(dac_data),   32'h800);
    check("en_drop.sleep", 32'(dac_sleep),  32'd1);
    check("en_drop.ur",    32'(underrun),   32'd1);

    // Re-enable: three pushes are not enough to start output.
    model_step("reen", 1, 0, 12'h000, 0);
    model_step("refill0", 1, 1, 12'h123, 0);
    model_step("refill1", 1, 1, 12'h456, 0);
    model_step("refill2", 1, 1, 12'h789, 0);
    for (int i = 0; i < 5; i++) model_step($sformatf("wait%0d", i), 1, 0, 12'h000, 0);
    check("wait.dac", 32'(dac_data), 32'h800);
    check("wait.wrt", 32'(dac_wrt),  32'd0);
    model_step("refill3", 1, 1, 12'hABC, 0);
    for (int i = 0; i < 4; i++) model_step($sformatf("first%0d", i), 1, 0, 12'h000, 0);
    check("first.dac", 32'(dac_data), 32'h923);
    check("first.raw", 32'(raw_data), 32'h123);

    // cnt=1, level=3, then asynchronous reset between clock edges.
    model_step("pre_rst", 1, 0, 12'h000, 0);
    check("pre_rst.level", 32'(fifo_level), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst", 0, 0, 12'h800, 12'h800, 0, 1, 0);
    en      = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_step("post_rst", 0, 0, 12'h000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
